// File: rtl/vrased_rst_ctrl.sv
// Reset controller for the VRASED monitors: turns level kill requests into a
// CPU reset of guaranteed minimum width and keeps sticky violation diagnostics.
module vrased_rst_ctrl #(
    parameter int N_SRC     = 4,
    parameter int MIN_PULSE = 16,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             por,
    input  logic [N_SRC-1:0] viol_req,
    input  logic [15:0]      pc,
    input  logic             cause_clr,
    output logic             cpu_rst,
    output logic             busy,
    output logic [N_SRC-1:0] cause,
    output logic [CNT_W-1:0] viol_cnt,
    output logic [15:0]      last_pc
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ASSERT = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;

    localparam logic [7:0] PULSE_LOAD = 8'(MIN_PULSE - 1);

    logic [1:0] state;
    logic [7:0] pulse_cnt;
    logic       trig;

    assign trig = |viol_req;

    always_ff @(posedge clk) begin
        if (por) begin
            state     <= S_IDLE;
            pulse_cnt <= '0;
            cpu_rst   <= 1'b0;
            busy      <= 1'b0;
            cause     <= '0;
            viol_cnt  <= '0;
            last_pc   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (trig) begin
                        state     <= S_ASSERT;
                        pulse_cnt <= PULSE_LOAD;
                        cpu_rst   <= 1'b1;
                        busy      <= 1'b1;
                        // A clear on the trigger edge is applied before the new bits land
                        cause     <= (cause_clr ? '0 : cause) | viol_req;
                        last_pc   <= pc;
                        if (viol_cnt != '1)
                            viol_cnt <= viol_cnt + 1'b1;
                    end else if (cause_clr) begin
                        cause   <= '0;
                        last_pc <= '0;
                    end
                end
                S_ASSERT: begin
                    cause <= cause | viol_req;
                    if (pulse_cnt == 8'd0) begin
                        if (trig) begin
                            state <= S_HOLD;
                        end else begin
                            state   <= S_IDLE;
                            cpu_rst <= 1'b0;
                            busy    <= 1'b0;
                        end
                    end else begin
                        pulse_cnt <= pulse_cnt - 8'd1;
                    end
                end
                S_HOLD: begin
                    cause <= cause | viol_req;
                    if (!trig) begin
                        state   <= S_IDLE;
                        cpu_rst <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    cpu_rst <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
